// File: rtl/tile_stream_driver.sv
// tile_stream_driver: streams 20x20 pixel tiles to the edge CHIP and collects its 324 edge bits per tile.
// Define EDGE_PACK_EN to pack edge bits into 18-bit rows instead of forwarding them one by one.
module tile_stream_driver #(
   parameter int BIT_LENGTH     = 4,
   parameter int LANES          = 5,
   parameter int WORDS_PER_TILE = 80,
   parameter int OUT_PER_TILE   = 324,
   parameter int TILE_W         = 12,
   parameter int ADDR_W         = 17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [TILE_W-1:0]             num_tiles,
   output logic                          busy,
   output logic                          done,
   output logic                          proto_err,
   output logic                          mem_rd,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic [LANES*BIT_LENGTH-1:0]   mem_data,
   output logic [BIT_LENGTH-1:0]         pixel_in0,
   output logic [BIT_LENGTH-1:0]         pixel_in1,
   output logic [BIT_LENGTH-1:0]         pixel_in2,
   output logic [BIT_LENGTH-1:0]         pixel_in3,
   output logic [BIT_LENGTH-1:0]         pixel_in4,
   output logic                          load_end,
   output logic                          chip_reset,
   input  logic                          readable,
   input  logic                          edge_out,
   output logic                          edge_valid,
   output logic                          edge_bit,
   output logic                          row_valid,
   output logic [17:0]                   row_data
);
   localparam int WW = $clog2(WORDS_PER_TILE);
   localparam int OW = $clog2(OUT_PER_TILE + 1);
   localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_TILE - 1);
   localparam logic [OW-1:0] O_FULL = OW'(OUT_PER_TILE);
   localparam logic [OW-1:0] O_LAST = OW'(OUT_PER_TILE - 1);
   typedef enum logic [2:0] {IDLE, TRST, LOAD, DRAIN, WAIT_OUT, FIN} state_t;
   state_t st, nxt;
   logic [TILE_W-1:0] n_tiles, tile;
   logic [ADDR_W-1:0] addr;
   logic [WW-1:0] w_cnt;
   logic [OW-1:0] out_cnt;
   logic [LANES*BIT_LENGTH-1:0] pix;
   logic rd_d, acc_start, acc, tile_end;
   assign acc_start = st == IDLE && start && !busy;
   // an edge bit is only taken while the last word is pending or presented, and never past a full tile
   assign acc = readable && (st == DRAIN || st == WAIT_OUT) && out_cnt != O_FULL;
   assign tile_end = st == WAIT_OUT && (out_cnt == O_FULL || (acc && out_cnt == O_LAST));
   assign chip_reset = st == TRST;
   assign mem_rd = st == LOAD;
   assign mem_addr = mem_rd ? addr : '0;
   assign load_end = st == WAIT_OUT;
   assign pixel_in0 = pix[0*BIT_LENGTH +: BIT_LENGTH];
   assign pixel_in1 = pix[1*BIT_LENGTH +: BIT_LENGTH];
   assign pixel_in2 = pix[2*BIT_LENGTH +: BIT_LENGTH];
   assign pixel_in3 = pix[3*BIT_LENGTH +: BIT_LENGTH];
   assign pixel_in4 = pix[4*BIT_LENGTH +: BIT_LENGTH];
   always_comb begin
      nxt = st;
      case (st)
         IDLE:     if (acc_start) nxt = (num_tiles == '0) ? FIN : TRST;
         TRST:     nxt = LOAD;
         LOAD:     if (w_cnt == W_LAST) nxt = DRAIN;
         DRAIN:    nxt = WAIT_OUT;
         WAIT_OUT: if (tile_end) nxt = (tile + 1'b1 == n_tiles) ? FIN : TRST;
         FIN:      nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         st        <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         proto_err <= 1'b0;
         n_tiles   <= '0;
         tile      <= '0;
         addr      <= '0;
         w_cnt     <= '0;
         out_cnt   <= '0;
         rd_d      <= 1'b0;
         pix       <= '0;
      end else begin
         st        <= nxt;
         done      <= st == FIN;
         busy      <= acc_start || (busy && !done);
         proto_err <= !acc_start && (proto_err || (readable && !acc));
         rd_d      <= mem_rd;
         if (rd_d) pix <= mem_data;
         if (acc_start) begin
            n_tiles <= num_tiles;
            tile    <= '0;
            addr    <= '0;
         end
         if (st == TRST) begin
            w_cnt   <= '0;
            out_cnt <= '0;
         end
         if (mem_rd) begin
            w_cnt <= w_cnt + 1'b1;
            addr  <= addr + 1'b1;
         end
         if (acc) out_cnt <= out_cnt + 1'b1;
         if (tile_end) tile <= tile + 1'b1;
      end
   end
`ifdef EDGE_PACK_EN
   logic [4:0]  col;
   logic [16:0] sh;
   assign edge_valid = 1'b0;
   assign edge_bit   = 1'b0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         col       <= '0;
         sh        <= '0;
         row_valid <= 1'b0;
         row_data  <= '0;
      end else begin
         row_valid <= 1'b0;
         if (st == TRST) col <= '0;
         else if (acc) begin
            sh  <= {edge_out, sh[16:1]};
            col <= (col == 5'd17) ? '0 : col + 1'b1;
            if (col == 5'd17) begin
               row_valid <= 1'b1;
               row_data  <= {edge_out, sh};
            end
         end
      end
   end
`else
   assign row_valid = 1'b0;
   assign row_data  = '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         edge_valid <= 1'b0;
         edge_bit   <= 1'b0;
      end else begin
         edge_valid <= acc;
         edge_bit   <= acc && edge_out;
      end
   end
`endif
endmodule

// File: tb/tb_tile_stream_driver.sv
// tb_tile_stream_driver: directed scenarios against a pixel memory and a CHIP responder.
module tb_tile_stream_driver;
`ifdef EDGE_PACK_EN
   localparam bit PACK = 1'b1;
`else
   localparam bit PACK = 1'b0;
`endif
   localparam int C_RD = 0, C_CR = 1, C_LE = 2, C_DN = 3, C_PIX = 4, C_LEB = 5;
   localparam int C_FRZ = 6, C_OVL = 7, C_EV = 8, C_EB = 9, C_RV = 10, C_RDAT = 11;
   logic clk = 1'b0;
   logic reset, start, readable, edge_out;
   logic [11:0] num_tiles;
   logic [19:0] mem_data = '0;
   logic busy, done, proto_err, mem_rd, load_end, chip_reset;
   logic edge_valid, edge_bit, row_valid;
   logic [16:0] mem_addr;
   logic [3:0] pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
   logic [17:0] row_data;
   logic [19:0] pix;
   int checks = 0, errors = 0;
   int cnt [12] = '{default: 0};
   logic [16:0] alog [2048];
   bit inj = 1'b0;
   tile_stream_driver dut (
      .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
      .busy(busy), .done(done), .proto_err(proto_err),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .pixel_in0(pixel_in0), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
      .pixel_in3(pixel_in3), .pixel_in4(pixel_in4),
      .load_end(load_end), .chip_reset(chip_reset),
      .readable(readable), .edge_out(edge_out),
      .edge_valid(edge_valid), .edge_bit(edge_bit),
      .row_valid(row_valid), .row_data(row_data)
   );
   assign pix = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};
   always #5 clk = ~clk;
   function automatic logic [19:0] lanes(input logic [16:0] a);
      logic [19:0] r;
      for (int k = 0; k < 5; k++) r[k*4 +: 4] = 4'(a[3:0] + k) ^ a[7:4];
      return r;
   endfunction
   // pixel memory: one-cycle read latency
   always @(posedge clk) if (mem_rd) mem_data <= lanes(mem_addr);
   // CHIP responder: emits 1,0,1,0... for as long as load_end is held
   initial begin
      bit ph;
      ph = 1'b1;
      readable = 1'b0;
      edge_out = 1'b0;
      forever begin
         @(negedge clk);
         if (chip_reset) ph = 1'b1;
         readable = load_end || inj;
         edge_out = ph;
         if (load_end) ph = ~ph;
      end
   end
   // monitor: event counters and anomaly tallies read by the scenario tasks
   initial begin
      bit h1, h2, le_prev;
      logic [16:0] h1a, h2a;
      logic [19:0] pix_prev;
      h1 = 0; h2 = 0; le_prev = 0; h1a = '0; h2a = '0; pix_prev = '0;
      forever begin
         @(negedge clk);
         if (chip_reset) cnt[C_CR]++;
         if (done) cnt[C_DN]++;
         if (!reset) begin
            h1 = 0; h2 = 0; le_prev = 0;
         end else begin
            if (mem_rd) begin
               if (cnt[C_RD] < 2048) alog[cnt[C_RD]] = mem_addr;
               cnt[C_RD]++;
            end
            if (load_end) cnt[C_LE]++;
            if (mem_rd && load_end) cnt[C_OVL]++;
            if (h2 && pix !== lanes(h2a)) cnt[C_PIX]++;
            if (load_end && !le_prev && !(h2 && h2a % 80 == 79)) cnt[C_LEB]++;
            if (load_end && le_prev && pix !== pix_prev) cnt[C_FRZ]++;
            if (edge_valid) begin
               if (edge_bit !== ~cnt[C_EV][0]) cnt[C_EB]++;
               cnt[C_EV]++;
            end
            if (row_valid) begin
               if (row_data !== 18'h15555) cnt[C_RDAT]++;
               cnt[C_RV]++;
            end
            h2 = h1; h2a = h1a; h1 = mem_rd; h1a = mem_addr;
            le_prev = load_end; pix_prev = pix;
         end
      end
   end
   task automatic pulse_start(input int n);
      @(negedge clk);
      num_tiles = 12'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done(input int lim, output bit ok);
      int t = 0;
      while (done !== 1'b1 && t < lim) begin
         @(negedge clk);
         t++;
      end
      ok = done === 1'b1;
   endtask
   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      num_tiles = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, proto_err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, proto_err}); end
      checks++;
      if ({mem_rd, mem_addr} !== 18'h0) begin errors++; $display("FAIL reset_mem got %h exp 0", {mem_rd, mem_addr}); end
      checks++;
      if ({pix, load_end, chip_reset} !== 22'h0) begin errors++; $display("FAIL reset_chip got %h exp 0", {pix, load_end, chip_reset}); end
      checks++;
      if ({edge_valid, edge_bit, row_valid, row_data} !== 21'h0) begin errors++; $display("FAIL reset_edge got %h exp 0", {edge_valid, edge_bit, row_valid, row_data}); end
      reset = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_zero_tiles;
      int s [12];
      s = cnt;
      @(negedge clk);
      num_tiles = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin errors++; $display("FAIL zero_cycle1 busy,done got %b exp 10", {busy, done}); end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b11) begin errors++; $display("FAIL zero_done busy,done got %b exp 11", {busy, done}); end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_after busy,done got %b exp 00", {busy, done}); end
      repeat (3) @(negedge clk);
      checks++;
      if (cnt[C_RD] - s[C_RD] !== 0) begin errors++; $display("FAIL zero_reads got %0d exp 0", cnt[C_RD] - s[C_RD]); end
      checks++;
      if (cnt[C_CR] - s[C_CR] !== 0) begin errors++; $display("FAIL zero_chip_reset got %0d exp 0", cnt[C_CR] - s[C_CR]); end
   endtask
   task automatic test_one_tile;
      int s [12];
      int bad;
      bit ok;
      s = cnt;
      pulse_start(1);
      wait_done(3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL one_done_timeout got 0 exp 1"); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL one_busy_after got %b exp 0", busy); end
      checks++;
      if (cnt[C_RD] - s[C_RD] !== 80) begin errors++; $display("FAIL one_reads got %0d exp 80", cnt[C_RD] - s[C_RD]); end
      bad = 0;
      for (int i = 0; i < 80; i++) if (alog[s[C_RD] + i] !== 17'(i)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL one_addr_seq bad %0d exp 0", bad); end
      checks++;
      if (cnt[C_CR] - s[C_CR] !== 1) begin errors++; $display("FAIL one_chip_reset got %0d exp 1", cnt[C_CR] - s[C_CR]); end
      checks++;
      if (cnt[C_LE] - s[C_LE] !== 324) begin errors++; $display("FAIL one_load_end_cycles got %0d exp 324", cnt[C_LE] - s[C_LE]); end
      checks++;
      if (cnt[C_DN] - s[C_DN] !== 1) begin errors++; $display("FAIL one_done_pulses got %0d exp 1", cnt[C_DN] - s[C_DN]); end
      checks++;
      if (cnt[C_PIX] - s[C_PIX] !== 0) begin errors++; $display("FAIL one_pixels bad %0d exp 0", cnt[C_PIX] - s[C_PIX]); end
      checks++;
      if ((cnt[C_LEB] - s[C_LEB]) + (cnt[C_FRZ] - s[C_FRZ]) !== 0) begin errors++; $display("FAIL one_load_end_align bad %0d exp 0", (cnt[C_LEB] - s[C_LEB]) + (cnt[C_FRZ] - s[C_FRZ])); end
      checks++;
      if (cnt[C_EV] - s[C_EV] !== (PACK ? 0 : 324)) begin errors++; $display("FAIL one_edge_valid got %0d exp %0d", cnt[C_EV] - s[C_EV], PACK ? 0 : 324); end
      checks++;
      if (cnt[C_EB] - s[C_EB] !== 0) begin errors++; $display("FAIL one_edge_bits bad %0d exp 0", cnt[C_EB] - s[C_EB]); end
      checks++;
      if (cnt[C_RV] - s[C_RV] !== (PACK ? 18 : 0)) begin errors++; $display("FAIL one_row_valid got %0d exp %0d", cnt[C_RV] - s[C_RV], PACK ? 18 : 0); end
      checks++;
      if (cnt[C_RDAT] - s[C_RDAT] !== 0) begin errors++; $display("FAIL one_row_data bad %0d exp 0", cnt[C_RDAT] - s[C_RDAT]); end
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL one_proto_err got %b exp 0", proto_err); end
   endtask
   task automatic test_three_tiles;
      int s [12];
      int bad;
      bit ok;
      s = cnt;
      pulse_start(3);
      wait_done(8000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL three_done_timeout got 0 exp 1"); end
      @(negedge clk);
      checks++;
      if (cnt[C_RD] - s[C_RD] !== 240) begin errors++; $display("FAIL three_reads got %0d exp 240", cnt[C_RD] - s[C_RD]); end
      bad = 0;
      for (int i = 0; i < 240; i++) if (alog[s[C_RD] + i] !== 17'(i)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL three_addr_seq bad %0d exp 0", bad); end
      checks++;
      if (cnt[C_CR] - s[C_CR] !== 3) begin errors++; $display("FAIL three_chip_reset got %0d exp 3", cnt[C_CR] - s[C_CR]); end
      checks++;
      if (cnt[C_LE] - s[C_LE] !== 972) begin errors++; $display("FAIL three_load_end_cycles got %0d exp 972", cnt[C_LE] - s[C_LE]); end
      checks++;
      if (cnt[C_OVL] - s[C_OVL] !== 0) begin errors++; $display("FAIL three_read_overlap got %0d exp 0", cnt[C_OVL] - s[C_OVL]); end
      checks++;
      if ((cnt[C_PIX] - s[C_PIX]) + (cnt[C_LEB] - s[C_LEB]) + (cnt[C_FRZ] - s[C_FRZ]) !== 0) begin errors++; $display("FAIL three_pixels bad %0d exp 0", (cnt[C_PIX] - s[C_PIX]) + (cnt[C_LEB] - s[C_LEB]) + (cnt[C_FRZ] - s[C_FRZ])); end
      checks++;
      if ((cnt[C_EV] - s[C_EV]) + (cnt[C_RV] - s[C_RV]) !== (PACK ? 54 : 972)) begin errors++; $display("FAIL three_edge_out got %0d exp %0d", (cnt[C_EV] - s[C_EV]) + (cnt[C_RV] - s[C_RV]), PACK ? 54 : 972); end
      checks++;
      if (cnt[C_DN] - s[C_DN] !== 1) begin errors++; $display("FAIL three_done_pulses got %0d exp 1", cnt[C_DN] - s[C_DN]); end
   endtask
   task automatic test_proto_err;
      int s [12];
      int t;
      bit ok;
      s = cnt;
      pulse_start(1);
      t = 0;
      while (mem_rd !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      @(posedge clk);
      inj = 1'b1;
      @(posedge clk);
      inj = 1'b0;
      @(negedge clk);
      checks++;
      if (proto_err !== 1'b1 || load_end !== 1'b0) begin errors++; $display("FAIL proto_set got err=%b load_end=%b exp 1,0", proto_err, load_end); end
      wait_done(3000, ok);
      @(negedge clk);
      checks++;
      if (!ok || proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got done=%b err=%b exp 1,1", ok, proto_err); end
      checks++;
      if (cnt[C_LE] - s[C_LE] !== 324) begin errors++; $display("FAIL proto_bits got %0d exp 324", cnt[C_LE] - s[C_LE]); end
      checks++;
      if ((cnt[C_EV] - s[C_EV]) + (cnt[C_RV] - s[C_RV]) !== (PACK ? 18 : 324)) begin errors++; $display("FAIL proto_edge_out got %0d exp %0d", (cnt[C_EV] - s[C_EV]) + (cnt[C_RV] - s[C_RV]), PACK ? 18 : 324); end
      pulse_start(1);
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear got %b exp 0", proto_err); end
      wait_done(3000, ok);
      @(negedge clk);
   endtask
   task automatic test_busy_ignore;
      int s [12];
      bit ok;
      s = cnt;
      pulse_start(1);
      repeat (30) @(negedge clk);
      num_tiles = 12'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3000, ok);
      num_tiles = 12'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (!ok || busy !== 1'b0) begin errors++; $display("FAIL busy_end got done=%b busy=%b exp 1,0", ok, busy); end
      repeat (5) @(negedge clk);
      checks++;
      if (cnt[C_RD] - s[C_RD] !== 80) begin errors++; $display("FAIL busy_reads got %0d exp 80", cnt[C_RD] - s[C_RD]); end
      checks++;
      if (cnt[C_CR] - s[C_CR] !== 1) begin errors++; $display("FAIL busy_chip_reset got %0d exp 1", cnt[C_CR] - s[C_CR]); end
   endtask
   task automatic test_abort;
      int s [12];
      int t, bad;
      bit ok;
      pulse_start(2);
      t = 0;
      while (!(mem_rd === 1'b1 && mem_addr === 17'd40) && t < 200) begin @(negedge clk); t++; end
      checks++;
      if (mem_addr !== 17'd40) begin errors++; $display("FAIL abort_reach_w40 got %0d exp 40", mem_addr); end
      reset = 1'b0;
      s = cnt;
      @(negedge clk);
      checks++;
      if ({busy, done, proto_err, mem_rd, mem_addr, pix, load_end, chip_reset, edge_valid, edge_bit, row_valid, row_data} !== 64'h0)
         begin errors++; $display("FAIL abort_outputs got %h exp 0", {busy, done, proto_err, mem_rd, mem_addr, pix, load_end, chip_reset, edge_valid, edge_bit, row_valid, row_data}); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ((cnt[C_DN] - s[C_DN]) + (cnt[C_CR] - s[C_CR]) !== 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", (cnt[C_DN] - s[C_DN]) + (cnt[C_CR] - s[C_CR])); end
      s = cnt;
      pulse_start(1);
      wait_done(3000, ok);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 80; i++) if (alog[s[C_RD] + i] !== 17'(i)) bad++;
      checks++;
      if (!ok || cnt[C_RD] - s[C_RD] !== 80 || bad !== 0) begin errors++; $display("FAIL abort_rerun got done=%b reads=%0d bad=%0d exp 1,80,0", ok, cnt[C_RD] - s[C_RD], bad); end
   endtask
   initial begin
      test_reset;
      test_zero_tiles;
      test_one_tile;
      test_three_tiles;
      test_proto_err;
      test_busy_ignore;
      test_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
